rob_walk_ctrl: RTL and testbench
================================

Name: rob_walk_ctrl

Overview:
Compact in-order reorder-buffer controller that drives the speculative rename table's commit and recovery interface.
- Holds renamed instructions in order (lrd, prd, need_to_wb, complete).
- Issues up to 2 in-order commits per cycle.
- On a flush, sequences ROLLBACK (rename table copies architectural table), then WALK (surviving uncommitted mappings replayed oldest-first, 2 per cycle), then returns to IDLE.

Parameters:
DEPTH, 16, number of ROB entries (power of 2, >= 4)
ROBID_WIDTH, 5, log2(DEPTH)+1; MSB is the wrap bit

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
enq0_valid  in  1  rename instr0 enqueue
enq0_lrd  in  5  logical destination register
enq0_prd  in  6  physical destination register
enq0_need_to_wb  in  1  instruction writes a register
enq1_valid / enq1_lrd / enq1_prd / enq1_need_to_wb  in  1/5/6/1  rename instr1 (younger than instr0)
enq_ready  out  1  two free entries and state IDLE
enq0_robid / enq1_robid  out  ROBID_WIDTH  robid assigned (tail, tail+1)
wb0_valid / wb0_robid  in  1/ROBID_WIDTH  completion port 0
wb1_valid / wb1_robid  in  1/ROBID_WIDTH  completion port 1
flush_valid  in  1  redirect request
flush_robid  in  ROBID_WIDTH  youngest surviving entry
commit0_valid / commit0_need_to_wb / commit0_lrd / commit0_prd  out  1/1/5/6  oldest commit
commit1_valid / commit1_need_to_wb / commit1_lrd / commit1_prd  out  1/1/5/6  second commit
rob_state  out  2  ROB_STATE_IDLE / ROB_STATE_ROLLBACK / ROB_STATE_WALK
rob_walk0_valid / rob_walk0_lrd / rob_walk0_prd  out  1/5/6  older walk entry
rob_walk1_valid / rob_walk1_lrd / rob_walk1_prd  out  1/5/6  younger walk entry
rob_empty  out  1  head == tail

Behaviour:
- Reset (async, reset_n low):
  - head = tail = walk_ptr = 0; all entry valid/complete bits cleared.
  - State = IDLE.
  - All commit/walk valids = 0; enq_ready = 1; rob_empty = 1.
- Occupancy:
  - count = tail - head, ROBID_WIDTH-bit subtraction.
  - Full when index bits are equal and wrap bits differ.
  - enq_ready = IDLE && (DEPTH - count >= 2).
- Enqueue (edge, only when enq_ready):
  - enq0 writes entry[tail]; enq1 writes entry[tail+1].
  - Tail advances by the number accepted.
  - enq1 without enq0 is ignored.
  - New entries: valid = 1, complete = 0.
- Writeback:
  - Sets complete on the addressed entry at the next edge, in any state.
  - Ignored if the entry is not valid (squashed or already committed).
  - Both ports to the same robid are legal.
- Commit (combinational from head, IDLE only):
  - commit0_valid = entry[head] valid && complete.
  - commit1_valid = commit0_valid && entry[head+1] valid && complete.
  - Committed entries are cleared and head advances at the edge.
  - Latency: wb in cycle N, commit visible in cycle N+1.
- Flush (accepted only in IDLE, and only when flush_robid names a valid entry; otherwise ignored):
  - Cycle N: this cycle's commits still retire. Same-cycle enqueue is dropped. Entries younger than flush_robid are invalidated. tail <= flush_robid+1. walk_ptr <= head after this cycle's commits.
  - N+1: state ROLLBACK for exactly 1 cycle. Commit and walk valids are 0.
  - If no survivors (walk_ptr == tail): ROLLBACK -> IDLE.
  - Otherwise ROLLBACK -> WALK.
- WALK:
  - rob_walk0 = entry[walk_ptr], valid iff walk_ptr != tail.
  - rob_walk1 = entry[walk_ptr+1], valid iff at least 2 remain.
  - walk_ptr advances by the number issued.
  - When the last entry is issued, state goes IDLE the next cycle.
  - A walk pair may share an lrd; walk1 is always the younger entry.
  - Commit and enqueue are held off throughout.
- Walk entries with need_to_wb = 0 are still issued, but with walk valid deasserted (no mapping).
- All pointer arithmetic wraps modulo 2*DEPTH; the index is the low log2(DEPTH) bits.
- Reset mid-ROLLBACK or mid-WALK returns immediately to the reset state.

Decomposition:
- Shared defines header holds:
  - ROB_STATE_IDLE = 2'd0, ROB_STATE_ROLLBACK = 2'd1, ROB_STATE_WALK = 2'd2.
  - PREG_RANGE, LREG_RANGE, and a ROBID_RANGE define.
- One natural sub-module: rob_entry_array, holding the payload storage with 2 write, 2 head-read and 2 walk-read ports.
- The FSM and pointers stay in rob_walk_ctrl.

Test Plan:
- Reset, then enqueue {lrd3->p40, lrd4->p41}, wb both same cycle -> next cycle commit0 = (3, 40), commit1 = (4, 41); then rob_empty = 1.
- Enqueue 16 entries -> enq_ready = 0 at count 15 and 16. Commit 2 -> enq_ready = 1 one cycle later. Tail wrap bit toggles.
- Enqueue 5 entries with robid 0..4, flush_robid = 2, no completions -> 1 cycle ROLLBACK. WALK cycle 1: walk0 = entry0, walk1 = entry1. WALK cycle 2: walk0 = entry2, walk1_valid = 0. Then IDLE with tail = 3. A wb to robid 4 is ignored.
- Entries 0 and 1 both write lrd5 (p50, p51), flush_robid = 1 -> single WALK cycle with walk0 = (5, 50), walk1 = (5, 51).
- Entry0 complete, flush_robid = 0 in the same cycle -> commit0 retires entry0, ROLLBACK for 1 cycle, then IDLE directly with no walk valids.
- Assert reset_n low during WALK -> same edge: state IDLE, walk valids 0, rob_empty = 1.

Source files
------------

// File: rtl/rob_walk_ctrl_pkg.sv
// Shared types and widths for the reorder-buffer walk controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package rob_walk_ctrl_pkg;

  localparam int LREG_W = 5;  // logical register index width
  localparam int PREG_W = 6;  // physical register index width

  typedef enum logic [1:0] {
    ROB_STATE_IDLE     = 2'd0,
    ROB_STATE_ROLLBACK = 2'd1,
    ROB_STATE_WALK     = 2'd2
  } rob_state_e;

  // Payload kept per ROB entry; valid/complete live with the control logic.
  typedef struct packed {
    logic              need_to_wb;
    logic [LREG_W-1:0] lrd;
    logic [PREG_W-1:0] prd;
  } rob_entry_t;

endpackage

// File: rtl/rob_walk_ctrl_if.sv
// Rename/writeback/flush requests into the ROB and commit/walk results out of it.
// Latency: n/a (wiring only).
// Backpressure: enq_ready gates enqueue; commit/walk outputs are valid-only.
// Modports: master = core side driving enq/wb/flush, slave = the ROB controller.
interface rob_walk_ctrl_if
  import rob_walk_ctrl_pkg::*;
#(
  parameter int ROBID_WIDTH = 5
);

  logic                   enq0_valid;
  logic [LREG_W-1:0]      enq0_lrd;
  logic [PREG_W-1:0]      enq0_prd;
  logic                   enq0_need_to_wb;
  logic                   enq1_valid;
  logic [LREG_W-1:0]      enq1_lrd;
  logic [PREG_W-1:0]      enq1_prd;
  logic                   enq1_need_to_wb;
  logic                   enq_ready;
  logic [ROBID_WIDTH-1:0] enq0_robid;
  logic [ROBID_WIDTH-1:0] enq1_robid;

  logic                   wb0_valid;
  logic [ROBID_WIDTH-1:0] wb0_robid;
  logic                   wb1_valid;
  logic [ROBID_WIDTH-1:0] wb1_robid;

  logic                   flush_valid;
  logic [ROBID_WIDTH-1:0] flush_robid;

  logic                   commit0_valid;
  logic                   commit0_need_to_wb;
  logic [LREG_W-1:0]      commit0_lrd;
  logic [PREG_W-1:0]      commit0_prd;
  logic                   commit1_valid;
  logic                   commit1_need_to_wb;
  logic [LREG_W-1:0]      commit1_lrd;
  logic [PREG_W-1:0]      commit1_prd;

  logic [1:0]             rob_state;
  logic                   rob_walk0_valid;
  logic [LREG_W-1:0]      rob_walk0_lrd;
  logic [PREG_W-1:0]      rob_walk0_prd;
  logic                   rob_walk1_valid;
  logic [LREG_W-1:0]      rob_walk1_lrd;
  logic [PREG_W-1:0]      rob_walk1_prd;
  logic                   rob_empty;

  modport master (
    output enq0_valid, enq0_lrd, enq0_prd, enq0_need_to_wb,
    output enq1_valid, enq1_lrd, enq1_prd, enq1_need_to_wb,
    input  enq_ready, enq0_robid, enq1_robid,
    output wb0_valid, wb0_robid, wb1_valid, wb1_robid,
    output flush_valid, flush_robid,
    input  commit0_valid, commit0_need_to_wb, commit0_lrd, commit0_prd,
    input  commit1_valid, commit1_need_to_wb, commit1_lrd, commit1_prd,
    input  rob_state, rob_empty,
    input  rob_walk0_valid, rob_walk0_lrd, rob_walk0_prd,
    input  rob_walk1_valid, rob_walk1_lrd, rob_walk1_prd
  );

  modport slave (
    input  enq0_valid, enq0_lrd, enq0_prd, enq0_need_to_wb,
    input  enq1_valid, enq1_lrd, enq1_prd, enq1_need_to_wb,
    output enq_ready, enq0_robid, enq1_robid,
    input  wb0_valid, wb0_robid, wb1_valid, wb1_robid,
    input  flush_valid, flush_robid,
    output commit0_valid, commit0_need_to_wb, commit0_lrd, commit0_prd,
    output commit1_valid, commit1_need_to_wb, commit1_lrd, commit1_prd,
    output rob_state, rob_empty,
    output rob_walk0_valid, rob_walk0_lrd, rob_walk0_prd,
    output rob_walk1_valid, rob_walk1_lrd, rob_walk1_prd
  );

endinterface

// File: rtl/rob_walk_ctrl_entry_array.sv
// ROB payload storage: 2 write ports (enqueue), 2 head reads (commit), 2 walk reads.
// Latency: writes land at the clock edge; reads are combinational.
// Backpressure: none; the controller only writes free slots.
module rob_entry_array
  import rob_walk_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we0,
  input  logic [IDX_W-1:0] waddr0,
  input  rob_entry_t       wdata0,
  input  logic             we1,
  input  logic [IDX_W-1:0] waddr1,
  input  rob_entry_t       wdata1,
  input  logic [IDX_W-1:0] head_addr0,
  input  logic [IDX_W-1:0] head_addr1,
  input  logic [IDX_W-1:0] walk_addr0,
  input  logic [IDX_W-1:0] walk_addr1,
  output rob_entry_t       head_dat0,
  output rob_entry_t       head_dat1,
  output rob_entry_t       walk_dat0,
  output rob_entry_t       walk_dat1
);

  // Payload needs no reset: an entry is only read once its valid bit is set.
  rob_entry_t mem_q [DEPTH];

  // The two write addresses are always tail and tail+1, so never collide.
  always_ff @(posedge clock) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign head_dat0 = mem_q[head_addr0];
  assign head_dat1 = mem_q[head_addr1];
  assign walk_dat0 = mem_q[walk_addr0];
  assign walk_dat1 = mem_q[walk_addr1];

endmodule

// File: rtl/rob_walk_ctrl.sv
// In-order ROB: 2-wide enqueue/commit, flush sequenced as ROLLBACK then WALK replay.
// Latency: wb at edge N -> commit visible in cycle N+1; flush -> 1 ROLLBACK cycle, then WALK.
// Backpressure: enq_ready low when fewer than 2 free entries or not IDLE.
// Ports: clock, reset_n (async active-low), rob_io (slave side of rob_walk_ctrl_if).
module rob_walk_ctrl
  import rob_walk_ctrl_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ROBID_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  rob_walk_ctrl_if.slave    rob_io
);

  localparam int IDX_W = ROBID_WIDTH - 1;
  localparam logic [ROBID_WIDTH:0] ENQ_LIMIT = (ROBID_WIDTH + 1)'(DEPTH - 2);

  typedef logic [ROBID_WIDTH-1:0] robid_t;

  function automatic logic [IDX_W-1:0] idx(input robid_t r);
    return r[IDX_W-1:0];
  endfunction

  rob_state_e       state_q, state_d;
  robid_t           head_q, head_d, tail_q, tail_d, walk_ptr_q, walk_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d, complete_q, complete_d;

  robid_t           head1, tail1, walk1_ptr, count, flush_off, remain;
  logic             is_idle, is_walk, enq_ready;
  logic             flush_ok, c0, c1, e0, e1, w0, w1;
  logic [IDX_W-1:0] rel;
  rob_entry_t       head_dat0, head_dat1, walk_dat0, walk_dat1;

  assign head1     = head_q + robid_t'(1);
  assign tail1     = tail_q + robid_t'(1);
  assign walk1_ptr = walk_ptr_q + robid_t'(1);
  assign count     = tail_q - head_q;
  assign remain    = tail_q - walk_ptr_q;
  assign flush_off = rob_io.flush_robid - head_q;

  assign is_idle   = (state_q == ROB_STATE_IDLE);
  assign is_walk   = (state_q == ROB_STATE_WALK);
  assign enq_ready = is_idle && ({1'b0, count} <= ENQ_LIMIT);

  // A flush must name an occupied slot; the range test rejects a stale wrap bit.
  assign flush_ok = is_idle && rob_io.flush_valid &&
                    valid_q[idx(rob_io.flush_robid)] && (flush_off < count);

  assign c0 = is_idle && valid_q[idx(head_q)] && complete_q[idx(head_q)];
  // When flushing at the head itself, the next entry is being squashed and must not retire.
  assign c1 = c0 && valid_q[idx(head1)] && complete_q[idx(head1)] &&
              !(flush_ok && (flush_off == '0));

  // Enqueue in a flush cycle is dropped.
  assign e0 = enq_ready && rob_io.enq0_valid && !flush_ok;
  assign e1 = e0 && rob_io.enq1_valid;

  assign w0 = is_walk && (remain != '0);
  assign w1 = is_walk && (remain >= robid_t'(2));

  assign head_d     = head_q + robid_t'(c0) + robid_t'(c1);
  assign tail_d     = flush_ok ? rob_io.flush_robid + robid_t'(1)
                               : tail_q + robid_t'(e0) + robid_t'(e1);
  assign walk_ptr_d = flush_ok ? head_d : walk_ptr_q + robid_t'(w0) + robid_t'(w1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROB_STATE_IDLE:     if (flush_ok) state_d = ROB_STATE_ROLLBACK;
      ROB_STATE_ROLLBACK: state_d = (walk_ptr_q == tail_q) ? ROB_STATE_IDLE : ROB_STATE_WALK;
      ROB_STATE_WALK:     if (remain <= robid_t'(2)) state_d = ROB_STATE_IDLE;
      default:            state_d = ROB_STATE_IDLE;
    endcase
  end

  // Priority: writeback set, then commit clear, then squash clear; enqueue only
  // touches free slots so it cannot overlap any of those.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    rel        = '0;
    if (rob_io.wb0_valid && valid_q[idx(rob_io.wb0_robid)]) complete_d[idx(rob_io.wb0_robid)] = 1'b1;
    if (rob_io.wb1_valid && valid_q[idx(rob_io.wb1_robid)]) complete_d[idx(rob_io.wb1_robid)] = 1'b1;
    if (c0) begin
      valid_d[idx(head_q)]    = 1'b0;
      complete_d[idx(head_q)] = 1'b0;
    end
    if (c1) begin
      valid_d[idx(head1)]    = 1'b0;
      complete_d[idx(head1)] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      // Age of slot i relative to head; anything older-than-or-equal to the flush point survives.
      rel = IDX_W'(i) - idx(head_q);
      if (flush_ok && (rel > idx(flush_off))) begin
        valid_d[i]    = 1'b0;
        complete_d[i] = 1'b0;
      end
    end
    if (e0) begin
      valid_d[idx(tail_q)]    = 1'b1;
      complete_d[idx(tail_q)] = 1'b0;
    end
    if (e1) begin
      valid_d[idx(tail1)]    = 1'b1;
      complete_d[idx(tail1)] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ROB_STATE_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      walk_ptr_q <= '0;
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      walk_ptr_q <= walk_ptr_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
    end
  end

  rob_entry_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_entry_array (
    .clock      (clock),
    .we0        (e0),
    .waddr0     (idx(tail_q)),
    .wdata0     ('{need_to_wb: rob_io.enq0_need_to_wb, lrd: rob_io.enq0_lrd, prd: rob_io.enq0_prd}),
    .we1        (e1),
    .waddr1     (idx(tail1)),
    .wdata1     ('{need_to_wb: rob_io.enq1_need_to_wb, lrd: rob_io.enq1_lrd, prd: rob_io.enq1_prd}),
    .head_addr0 (idx(head_q)),
    .head_addr1 (idx(head1)),
    .walk_addr0 (idx(walk_ptr_q)),
    .walk_addr1 (idx(walk1_ptr)),
    .head_dat0  (head_dat0),
    .head_dat1  (head_dat1),
    .walk_dat0  (walk_dat0),
    .walk_dat1  (walk_dat1)
  );

  assign rob_io.enq_ready  = enq_ready;
  assign rob_io.enq0_robid = tail_q;
  assign rob_io.enq1_robid = tail1;

  assign rob_io.commit0_valid      = c0;
  assign rob_io.commit0_need_to_wb = head_dat0.need_to_wb;
  assign rob_io.commit0_lrd        = head_dat0.lrd;
  assign rob_io.commit0_prd        = head_dat0.prd;
  assign rob_io.commit1_valid      = c1;
  assign rob_io.commit1_need_to_wb = head_dat1.need_to_wb;
  assign rob_io.commit1_lrd        = head_dat1.lrd;
  assign rob_io.commit1_prd        = head_dat1.prd;

  // Entries without a destination still consume a walk slot but carry no mapping.
  assign rob_io.rob_walk0_valid = w0 && walk_dat0.need_to_wb;
  assign rob_io.rob_walk0_lrd   = walk_dat0.lrd;
  assign rob_io.rob_walk0_prd   = walk_dat0.prd;
  assign rob_io.rob_walk1_valid = w1 && walk_dat1.need_to_wb;
  assign rob_io.rob_walk1_lrd   = walk_dat1.lrd;
  assign rob_io.rob_walk1_prd   = walk_dat1.prd;

  assign rob_io.rob_state = state_q;
  assign rob_io.rob_empty = (head_q == tail_q);

endmodule

// File: tb/tb_rob_walk_ctrl.sv
module tb_rob_walk_ctrl;
  import rob_walk_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rob_walk_ctrl_if #(.ROBID_WIDTH(5)) io();

  rob_walk_ctrl #(.DEPTH(16), .ROBID_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rob_io  (io)
  );

  typedef struct packed {
    logic [4:0] lrd;
    logic [5:0] prd;
  } pay_t;

  pay_t cq[$];
  pay_t wq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic pay_t mk(input int lrd, input int prd);
    pay_t p;
    p.lrd = 5'(lrd);
    p.prd = 6'(prd);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic sb_cmp(input string name, input bit has_exp, input pay_t exp, input pay_t act);
    n_total++;
    if (!has_exp)
      $display("FAIL %s: unexpected output lrd=%0d prd=%0d, nothing expected", name, act.lrd, act.prd);
    else if (act === exp) n_pass++;
    else
      $display("FAIL %s: got lrd=%0d prd=%0d expected lrd=%0d prd=%0d",
               name, act.lrd, act.prd, exp.lrd, exp.prd);
  endtask

  // Scoreboard monitor: consumes expected commit/walk payloads whenever the DUT presents one.
  always @(negedge clock) begin
    if (reset_n) begin
      if (io.commit0_valid) begin
        bit h; pay_t e;
        h = (cq.size() != 0); e = h ? cq.pop_front() : '0;
        sb_cmp("commit0", h, e, mk(io.commit0_lrd, io.commit0_prd));
      end
      if (io.commit1_valid) begin
        bit h; pay_t e;
        h = (cq.size() != 0); e = h ? cq.pop_front() : '0;
        sb_cmp("commit1", h, e, mk(io.commit1_lrd, io.commit1_prd));
      end
      if (io.rob_walk0_valid) begin
        bit h; pay_t e;
        h = (wq.size() != 0); e = h ? wq.pop_front() : '0;
        sb_cmp("walk0", h, e, mk(io.rob_walk0_lrd, io.rob_walk0_prd));
      end
      if (io.rob_walk1_valid) begin
        bit h; pay_t e;
        h = (wq.size() != 0); e = h ? wq.pop_front() : '0;
        sb_cmp("walk1", h, e, mk(io.rob_walk1_lrd, io.rob_walk1_prd));
      end
    end
  end

  task automatic idle_inputs();
    io.enq0_valid = 0; io.enq0_lrd = 0; io.enq0_prd = 0; io.enq0_need_to_wb = 0;
    io.enq1_valid = 0; io.enq1_lrd = 0; io.enq1_prd = 0; io.enq1_need_to_wb = 0;
    io.wb0_valid = 0; io.wb0_robid = 0; io.wb1_valid = 0; io.wb1_robid = 0;
    io.flush_valid = 0; io.flush_robid = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    @(posedge clock); #1;
    reset_n = 1;
  endtask

  task automatic enq0(input int lrd, input int prd);
    io.enq0_valid = 1; io.enq0_lrd = 5'(lrd); io.enq0_prd = 6'(prd); io.enq0_need_to_wb = 1;
  endtask

  task automatic enq1(input int lrd, input int prd);
    io.enq1_valid = 1; io.enq1_lrd = 5'(lrd); io.enq1_prd = 6'(prd); io.enq1_need_to_wb = 1;
  endtask

  task automatic flush(input int robid);
    io.flush_valid = 1; io.flush_robid = 5'(robid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_n = 0;
    #12;
    chk("rst_enq_ready", io.enq_ready, 1);
    chk("rst_empty", io.rob_empty, 1);
    chk("rst_state", io.rob_state, ROB_STATE_IDLE);
    chk("rst_commit0", io.commit0_valid, 0);
    chk("rst_walk0", io.rob_walk0_valid, 0);
    chk("rst_tail", io.enq0_robid, 0);
    @(posedge clock); #1;
    reset_n = 1;

    // Two-wide enqueue, both completed together, both commit next cycle.
    enq0(3, 40); enq1(4, 41);
    @(negedge clock);
    chk("t1_robid0", io.enq0_robid, 0);
    chk("t1_robid1", io.enq1_robid, 1);
    step();
    io.wb0_valid = 1; io.wb0_robid = 0; io.wb1_valid = 1; io.wb1_robid = 1;
    cq.push_back(mk(3, 40)); cq.push_back(mk(4, 41));
    @(negedge clock);
    chk("t1_no_early_commit", io.commit0_valid, 0);
    step();
    @(negedge clock);
    chk("t1_commit0_v", io.commit0_valid, 1);
    chk("t1_commit1_v", io.commit1_valid, 1);
    step();
    @(negedge clock);
    chk("t1_empty", io.rob_empty, 1);
    step();

    // Fill from head=tail=2: 16 entries, robids 2..17, tail wraps to 18.
    for (int k = 0; k < 8; k++) begin
      enq0(2 + 2 * k, 22 + 2 * k); enq1(3 + 2 * k, 23 + 2 * k);
      @(negedge clock);
      chk("t2_ready_filling", io.enq_ready, 1);
      step();
    end
    enq0(31, 63);  // must be dropped: ROB is full
    io.wb0_valid = 1; io.wb0_robid = 2; cq.push_back(mk(2, 22));
    @(negedge clock);
    chk("t2_full_ready", io.enq_ready, 0);
    chk("t2_full_not_empty", io.rob_empty, 0);
    chk("t2_tail_wrap", io.enq0_robid, 18);
    step();
    io.wb0_valid = 1; io.wb0_robid = 3; cq.push_back(mk(3, 23));
    @(negedge clock);
    chk("t2_commit_a", io.commit0_valid, 1);
    chk("t2_ready_16", io.enq_ready, 0);
    chk("t2_enq_dropped", io.enq0_robid, 18);
    step();
    @(negedge clock);
    chk("t2_ready_15", io.enq_ready, 0);
    chk("t2_commit_b", io.commit0_valid, 1);
    chk("t2_commit_b1", io.commit1_valid, 0);
    step();
    @(negedge clock);
    chk("t2_ready_14", io.enq_ready, 1);
    do_reset();

    // Five entries, flush at robid 2, walk 3 survivors over two cycles.
    enq0(10, 30); enq1(11, 31); step();
    enq0(12, 32); enq1(13, 33); step();
    enq0(14, 34); step();
    flush(2);
    wq.push_back(mk(10, 30)); wq.push_back(mk(11, 31)); wq.push_back(mk(12, 32));
    @(negedge clock);
    chk("t3_flush_cycle_state", io.rob_state, ROB_STATE_IDLE);
    step();
    @(negedge clock);
    chk("t3_rollback", io.rob_state, ROB_STATE_ROLLBACK);
    chk("t3_rb_commit", io.commit0_valid, 0);
    chk("t3_rb_walk", io.rob_walk0_valid, 0);
    chk("t3_rb_ready", io.enq_ready, 0);
    step();
    @(negedge clock);
    chk("t3_walk1_state", io.rob_state, ROB_STATE_WALK);
    chk("t3_walk1_w0", io.rob_walk0_valid, 1);
    chk("t3_walk1_w1", io.rob_walk1_valid, 1);
    step();
    @(negedge clock);
    chk("t3_walk2_state", io.rob_state, ROB_STATE_WALK);
    chk("t3_walk2_w0", io.rob_walk0_valid, 1);
    chk("t3_walk2_w1", io.rob_walk1_valid, 0);
    step();
    @(negedge clock);
    chk("t3_idle", io.rob_state, ROB_STATE_IDLE);
    chk("t3_tail", io.enq0_robid, 3);
    chk("t3_idle_walk", io.rob_walk0_valid, 0);
    step();
    io.wb0_valid = 1; io.wb0_robid = 4;  // squashed entry, ignored
    step();
    @(negedge clock);
    chk("t3_wb4_no_commit", io.commit0_valid, 0);
    chk("t3_not_empty", io.rob_empty, 0);
    step();
    io.wb0_valid = 1; io.wb0_robid = 0; io.wb1_valid = 1; io.wb1_robid = 1;
    cq.push_back(mk(10, 30)); cq.push_back(mk(11, 31));
    step();
    io.wb0_valid = 1; io.wb0_robid = 2; cq.push_back(mk(12, 32));
    @(negedge clock);
    chk("t3_commit_pair0", io.commit0_valid, 1);
    chk("t3_commit_pair1", io.commit1_valid, 1);
    step();
    @(negedge clock);
    chk("t3_commit_last", io.commit0_valid, 1);
    chk("t3_commit_last1", io.commit1_valid, 0);
    step();
    @(negedge clock);
    chk("t3_drained", io.rob_empty, 1);
    do_reset();

    // Walk pair sharing one lrd: walk1 must be the younger mapping.
    enq0(5, 50); enq1(5, 51); step();
    flush(1);
    wq.push_back(mk(5, 50)); wq.push_back(mk(5, 51));
    step();
    @(negedge clock);
    chk("t4_rollback", io.rob_state, ROB_STATE_ROLLBACK);
    step();
    @(negedge clock);
    chk("t4_walk_state", io.rob_state, ROB_STATE_WALK);
    chk("t4_w0", io.rob_walk0_valid, 1);
    chk("t4_w1", io.rob_walk1_valid, 1);
    step();
    @(negedge clock);
    chk("t4_idle", io.rob_state, ROB_STATE_IDLE);
    chk("t4_idle_walk", io.rob_walk0_valid, 0);
    do_reset();

    // Flush at the head while it commits: no survivors, ROLLBACK straight to IDLE.
    enq0(7, 60); enq1(8, 61); step();
    io.wb0_valid = 1; io.wb0_robid = 0; step();
    flush(0); cq.push_back(mk(7, 60));
    @(negedge clock);
    chk("t5_commit0", io.commit0_valid, 1);
    chk("t5_commit1", io.commit1_valid, 0);
    step();
    @(negedge clock);
    chk("t5_rollback", io.rob_state, ROB_STATE_ROLLBACK);
    chk("t5_rb_walk", io.rob_walk0_valid, 0);
    step();
    @(negedge clock);
    chk("t5_idle", io.rob_state, ROB_STATE_IDLE);
    chk("t5_w0", io.rob_walk0_valid, 0);
    chk("t5_w1", io.rob_walk1_valid, 0);
    chk("t5_empty", io.rob_empty, 1);
    chk("t5_tail", io.enq0_robid, 1);
    do_reset();

    // Reset asserted in the middle of a walk.
    enq0(1, 11); enq1(2, 12); step();
    enq0(3, 13); enq1(6, 16); step();
    flush(3);
    wq.push_back(mk(1, 11)); wq.push_back(mk(2, 12));
    step();
    @(negedge clock);
    chk("t6_rollback", io.rob_state, ROB_STATE_ROLLBACK);
    step();
    @(negedge clock);
    chk("t6_walking", io.rob_state, ROB_STATE_WALK);
    chk("t6_w1_before_rst", io.rob_walk1_valid, 1);
    #1 reset_n = 0;
    #1;
    chk("t6_rst_state", io.rob_state, ROB_STATE_IDLE);
    chk("t6_rst_w0", io.rob_walk0_valid, 0);
    chk("t6_rst_w1", io.rob_walk1_valid, 0);
    chk("t6_rst_empty", io.rob_empty, 1);
    @(posedge clock); #1;
    reset_n = 1;
    @(negedge clock);

    chk("commit_queue_drained", cq.size(), 0);
    chk("walk_queue_drained", wq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
